// File: rtl/dmem_responder_if.sv
// Load/store port between the datapath (master) and the data-memory responder (slave).
// Request and response channels each use their own valid/ready handshake.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a single outstanding request, fixed response
// latency and a held response; misaligned/out-of-range accesses return an error.
module dmem_responder #(
  parameter int AW      = 6,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam int NW = 1 << AW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [NW-1:0][31:0]   mem_q, mem_d;

  logic [AW-1:0] index;
  logic          misaligned, oor, err, accept;

  assign index      = bus.req_addr[AW+1:2];
  assign misaligned = |bus.req_addr[1:0];
  assign oor        = |bus.req_addr[31:AW+2];
  assign err        = misaligned | oor;
  assign accept     = bus.req_valid && (state_q == S_IDLE);

  // Handshake outputs depend on registered state only.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_d   = mem_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.req_we && !err) mem_d[index] = bus.req_wdata;
          rdata_d = (!bus.req_we && !err) ? mem_q[index] : 32'd0;
          err_d   = err;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY > 1) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Drives three responders (LATENCY 1, 2, 7) with directed and random load/store
// traffic and compares against a word-array memory model.
module tb_dmem_responder;
  localparam int NW = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req_valid;
  logic        req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  rdy, vld, rerr;
  logic [31:0] rdat [3];
  logic [31:0] mdl [3][NW];
  int          tests = 0, fails = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if if0 ();
  dmem_responder_if if1 ();
  dmem_responder_if if2 ();

  assign if0.req_valid = req_valid[0];
  assign if1.req_valid = req_valid[1];
  assign if2.req_valid = req_valid[2];
  assign if0.req_we = req_we;       assign if1.req_we = req_we;       assign if2.req_we = req_we;
  assign if0.req_addr = req_addr;   assign if1.req_addr = req_addr;   assign if2.req_addr = req_addr;
  assign if0.req_wdata = req_wdata; assign if1.req_wdata = req_wdata; assign if2.req_wdata = req_wdata;
  assign if0.resp_ready = resp_ready;
  assign if1.resp_ready = resp_ready;
  assign if2.resp_ready = resp_ready;
  assign rdy  = {if2.req_ready, if1.req_ready, if0.req_ready};
  assign vld  = {if2.resp_valid, if1.resp_valid, if0.resp_valid};
  assign rerr = {if2.resp_err, if1.resp_err, if0.resp_err};
  assign rdat[0] = if0.resp_rdata;
  assign rdat[1] = if1.resp_rdata;
  assign rdat[2] = if2.resp_rdata;

  dmem_responder #(.AW(6), .LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(if0));
  dmem_responder #(.AW(6), .LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(if1));
  dmem_responder #(.AW(6), .LATENCY(7)) u_l7 (.clk(clk), .reset(reset), .bus(if2));

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 7);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++)
      for (int w = 0; w < NW; w++) mdl[d][w] = 32'd0;
  endtask

  // One full transaction on responder d, entered and left at a negedge in IDLE.
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold, output int acc_cyc);
    logic        e;
    logic [31:0] er;
    int          lat;
    chk("idle_ready", {31'd0, rdy[d]}, 32'd1);
    req_valid[d] = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    resp_ready = (hold == 0);
    e  = (addr % 4 != 0) || (addr / 4 >= NW);
    er = 32'd0;
    if (!e) begin
      if (we) mdl[d][addr / 4] = wdata;
      else    er = mdl[d][addr / 4];
    end
    @(negedge clk);
    acc_cyc = cyc;
    req_valid[d] = 1'b0; req_addr = $urandom; req_we = 1'($urandom); req_wdata = $urandom;
    lat = 1;
    while (vld[d] !== 1'b1 && lat < 40) begin
      chk("busy_not_ready", {31'd0, rdy[d]}, 32'd0);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(lat_of(d)));
    chk("rdata", rdat[d], er);
    chk("err", {31'd0, rerr[d]}, {31'd0, e});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, vld[d]}, 32'd1);
      chk("hold_rdata", rdat[d], er);
      chk("hold_err", {31'd0, rerr[d]}, {31'd0, e});
      chk("hold_ready", {31'd0, rdy[d]}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("ready_after", {31'd0, rdy[d]}, 32'd1);
    chk("valid_after", {31'd0, vld[d]}, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 5) == 0) a = $urandom;
    else a = 32'($urandom_range(0, NW - 1) * 4);
    if ($urandom_range(0, 7) == 0) a = a | 32'd2;
    return a;
  endfunction

  initial begin
    int ac, prev;
    req_valid = '0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", {31'd0, rdy[d]}, 32'd1);
      chk("rst_valid", {31'd0, vld[d]}, 32'd0);
      chk("rst_rdata", rdat[d], 32'd0);
      chk("rst_err", {31'd0, rerr[d]}, 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);

    txn(1, 1'b0, 32'h0, 32'h0, 0, ac);
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 0, ac);
    txn(1, 1'b0, 32'h10, 32'h0, 0, ac);
    txn(1, 1'b0, 32'h14, 32'h0, 0, ac);
    txn(1, 1'b1, 32'h12, 32'h12345678, 0, ac);
    txn(1, 1'b0, 32'h10, 32'h0, 0, ac);
    txn(1, 1'b0, 32'h100, 32'h0, 0, ac);
    txn(1, 1'b0, 32'h10, 32'h0, 5, ac);

    // Back-to-back random stream per latency with resp_ready held high.
    for (int d = 0; d < 3; d++) begin
      prev = 0;
      for (int i = 0; i < 40; i++) begin
        txn(d, 1'($urandom), rand_addr(), $urandom, 0, ac);
        if (i > 0) chk("spacing", 32'(ac - prev), 32'(lat_of(d) + 1));
        prev = ac;
      end
      txn(d, 1'b0, rand_addr(), 32'h0, $urandom_range(1, 4), ac);
    end

    // Reset while the LATENCY=7 responder is waiting on a store.
    txn(2, 1'b1, 32'h20, 32'hA5A5_0F0F, 0, ac);
    req_valid[2] = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'h1111_2222;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, vld[2]}, 32'd0);
    chk("midrst_ready", {31'd0, rdy[2]}, 32'd1);
    reset = 1'b1;
    clear_model();
    txn(2, 1'b0, 32'h20, 32'h0, 0, ac);
    txn(2, 1'b0, 32'h24, 32'h0, 0, ac);
    txn(1, 1'b0, 32'h10, 32'h0, 0, ac);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
